stage_chain: RTL and testbench

// Parametrised successor of the single match-action stage wrapper. Chains NUM_STAGES

---
 rtl/stage_chain.sv | 214 +++++++++++++++++++++
 tb/tb_stage_chain.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_chain.sv
// Chain of NUM_STAGES fixed-latency match-action stages with per-stage bypass,
// a credit-controlled output FIFO, PHV counters and latency/overflow flags.

module stage_chain_pipe #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         axis_clk,
  input  logic         aresetn,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  logic [DEPTH-1:0] vld;
  logic [W-1:0]     dat [DEPTH];

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) vld[i] <= vld[i-1];
    end
  end

  // NOTE: payload registers carry no reset; only the valid bits need a defined value.
  always_ff @(posedge axis_clk) begin
    dat[0] <= in_data;
    for (int i = 1; i < DEPTH; i++) dat[i] <= dat[i-1];
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];
endmodule

module stage_chain_stage #(
  parameter int PHV_LEN   = 1579,
  parameter int KEY_LEN   = 896,
  parameter int STAGE_LAT = 8
) (
  input  logic               axis_clk,
  input  logic               aresetn,
  input  logic               phv_in_valid,
  input  logic [PHV_LEN-1:0] phv_in,
  output logic               phv_out_valid,
  output logic [PHV_LEN-1:0] phv_out
);
  logic [KEY_LEN-1:0] key;
  logic [PHV_LEN-1:0] phv_act;

  // No table entries are installed: every lookup misses and the default
  // action writes the key fields back unchanged.
  assign key     = phv_in[KEY_LEN-1:0];
  assign phv_act = {phv_in[PHV_LEN-1:KEY_LEN], key};

  stage_chain_pipe #(.W(PHV_LEN), .DEPTH(STAGE_LAT)) u_pipe (
    .axis_clk (axis_clk),
    .aresetn  (aresetn),
    .in_valid (phv_in_valid),
    .in_data  (phv_act),
    .out_valid(phv_out_valid),
    .out_data (phv_out)
  );
endmodule

module stage_chain #(
  parameter int PHV_LEN    = 1024+7+24*8+5*20+256,
  parameter int KEY_LEN    = 896,
  parameter int NUM_STAGES = 5,
  parameter int STAGE_LAT  = 8,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                          axis_clk,
  input  logic                          aresetn,
  input  logic [PHV_LEN-1:0]            phv_in,
  input  logic                          phv_in_valid,
  output logic                          phv_in_ready,
  output logic [PHV_LEN-1:0]            phv_out,
  output logic                          phv_out_valid,
  input  logic                          phv_out_ready,
  input  logic [NUM_STAGES-1:0]         stage_bypass,
  output logic [NUM_STAGES-1:0]         bypass_active,
  output logic [$clog2(FIFO_DEPTH):0]   inflight,
  output logic [31:0]                   phv_in_cnt,
  output logic [31:0]                   phv_out_cnt,
  output logic                          lat_err,
  output logic                          ovf_err
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LAT = NUM_STAGES * STAGE_LAT;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic               ready_en, accept, pop, pending;
  logic               s_valid [NUM_STAGES+1];
  logic [PHV_LEN-1:0] s_data  [NUM_STAGES+1];
  logic               c_valid;
  logic [PHV_LEN-1:0] c_data;

  // A pending mask change closes the input so the chain drains before it applies.
  assign pending      = (stage_bypass != bypass_active);
  assign phv_in_ready = ready_en && !pending && (inflight < FULL_CNT);
  assign accept       = phv_in_valid && phv_in_ready;
  assign pop          = phv_out_valid && phv_out_ready;

  assign s_valid[0] = accept;
  assign s_data[0]  = phv_in;

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    logic               st_valid, byp_valid;
    logic [PHV_LEN-1:0] st_data, byp_data;

    stage_chain_stage #(.PHV_LEN(PHV_LEN), .KEY_LEN(KEY_LEN), .STAGE_LAT(STAGE_LAT)) u_stage (
      .axis_clk     (axis_clk),
      .aresetn      (aresetn),
      .phv_in_valid (s_valid[i]),
      .phv_in       (s_data[i]),
      .phv_out_valid(st_valid),
      .phv_out      (st_data)
    );

    stage_chain_pipe #(.W(PHV_LEN), .DEPTH(STAGE_LAT)) u_bypass (
      .axis_clk (axis_clk),
      .aresetn  (aresetn),
      .in_valid (s_valid[i]),
      .in_data  (s_data[i]),
      .out_valid(byp_valid),
      .out_data (byp_data)
    );

    assign s_valid[i+1] = bypass_active[i] ? byp_valid : st_valid;
    assign s_data[i+1]  = bypass_active[i] ? byp_data  : st_data;
  end

  assign c_valid = s_valid[NUM_STAGES];
  assign c_data  = s_data[NUM_STAGES];

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      ready_en      <= 1'b0;
      bypass_active <= '0;
      inflight      <= '0;
      phv_in_cnt    <= '0;
      phv_out_cnt   <= '0;
    end else begin
      ready_en <= 1'b1;
      if (inflight == '0 && !accept) bypass_active <= stage_bypass;
      if (accept && !pop)      inflight <= inflight + 1'b1;
      else if (pop && !accept) inflight <= inflight - 1'b1;
      if (accept) phv_in_cnt  <= phv_in_cnt + 32'd1;
      if (pop)    phv_out_cnt <= phv_out_cnt + 32'd1;
    end
  end

  // Output FIFO: registered head (phv_out) backed by a FIFO_DEPTH-entry store.
  logic [PHV_LEN-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        m_cnt;
  logic               load_out, direct, m_wr, m_rd;

  assign load_out = !phv_out_valid || pop;
  assign direct   = c_valid && load_out && (m_cnt == '0);
  assign m_wr     = c_valid && !direct && (m_cnt != FULL_CNT);
  assign m_rd     = load_out && (m_cnt != '0);

  always_ff @(posedge axis_clk) begin
    if (m_wr) mem[wr_ptr] <= c_data;
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      m_cnt         <= '0;
      phv_out_valid <= 1'b0;
      phv_out       <= '0;
    end else begin
      if (m_wr) wr_ptr <= wr_ptr + 1'b1;
      if (m_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({m_wr, m_rd})
        2'b10:   m_cnt <= m_cnt + 1'b1;
        2'b01:   m_cnt <= m_cnt - 1'b1;
        default: m_cnt <= m_cnt;
      endcase
      if (load_out) begin
        if (m_rd) begin
          phv_out_valid <= 1'b1;
          phv_out       <= mem[rd_ptr];
        end else if (direct) begin
          phv_out_valid <= 1'b1;
          phv_out       <= c_data;
        end else begin
          phv_out_valid <= 1'b0;
        end
      end
    end
  end

  // Shadow of accepts delayed by the nominal chain latency.
  logic [LAT-1:0] shadow;

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      shadow  <= '0;
      lat_err <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      shadow[0] <= accept;
      for (int i = 1; i < LAT; i++) shadow[i] <= shadow[i-1];
      if (shadow[LAT-1] != c_valid)         lat_err <= 1'b1;
      if (c_valid && (m_cnt == FULL_CNT))   ovf_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_stage_chain.sv
// Directed bench for stage_chain: latency, backpressure, bypass drain,
// throttled traffic with scoreboard, mid-traffic reset and counter wrap.

module tb_stage_chain;
  localparam int PHV_LEN = 1024+7+24*8+5*20+256;
  localparam int NS      = 5;
  localparam int LAT1    = 5*8 + 1;

  logic               axis_clk, aresetn;
  logic [PHV_LEN-1:0] phv_in, phv_out;
  logic               phv_in_valid, phv_in_ready, phv_out_valid, phv_out_ready;
  logic [NS-1:0]      stage_bypass, bypass_active;
  logic [5:0]         inflight;
  logic [31:0]        phv_in_cnt, phv_out_cnt;
  logic               lat_err, ovf_err;

  stage_chain dut (
    .axis_clk     (axis_clk),
    .aresetn      (aresetn),
    .phv_in       (phv_in),
    .phv_in_valid (phv_in_valid),
    .phv_in_ready (phv_in_ready),
    .phv_out      (phv_out),
    .phv_out_valid(phv_out_valid),
    .phv_out_ready(phv_out_ready),
    .stage_bypass (stage_bypass),
    .bypass_active(bypass_active),
    .inflight     (inflight),
    .phv_in_cnt   (phv_in_cnt),
    .phv_out_cnt  (phv_out_cnt),
    .lat_err      (lat_err),
    .ovf_err      (ovf_err)
  );

  initial begin
    axis_clk = 1'b0;
    forever #5 axis_clk = ~axis_clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int                 n_err = 0, n_checks = 0;
  int                 n_acc = 0, n_pop = 0, n_spurious = 0;
  int                 cyc = 0, last_acc_cyc = 0, first_out_cyc = -1;
  int unsigned        seq = 0;
  logic [PHV_LEN-1:0] exp_q [$];
  logic               hold_prev = 1'b0;
  logic [PHV_LEN-1:0] hold_data;

  function automatic logic [PHV_LEN-1:0] mk(input int unsigned n);
    logic [PHV_LEN-1:0] p;
    p = '0;
    for (int k = 0; k < PHV_LEN/32; k++) p[k*32 +: 32] = n * 32'h9E3779B1 + k;
    p[PHV_LEN-1 -: 16] = n[15:0];
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_phv(input string tag, input logic [PHV_LEN-1:0] obs, input logic [PHV_LEN-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed ..%h expected ..%h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  // One clock: record handshakes at the falling edge, return 1 ns after the rising edge.
  task automatic tick();
    @(negedge axis_clk);
    if (phv_in_valid && phv_in_ready) begin
      exp_q.push_back(phv_in);
      n_acc++;
      seq++;
      last_acc_cyc = cyc;
    end
    if (phv_out_valid) begin
      if (first_out_cyc < 0) first_out_cyc = cyc;
      if (hold_prev) chk_phv("hold_stable", phv_out, hold_data);
    end
    hold_prev = phv_out_valid && !phv_out_ready;
    hold_data = phv_out;
    if (phv_out_valid && phv_out_ready) begin
      n_pop++;
      if (exp_q.size() == 0) n_spurious++;
      else chk_phv("payload", phv_out, exp_q.pop_front());
    end
    @(posedge axis_clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input int n_new, input int budget, input int vpct, input int rpct);
    int target, k;
    target = n_acc + n_new;
    k = 0;
    while ((n_acc < target || exp_q.size() != 0) && k < budget) begin
      phv_in_valid  = (n_acc < target) && ($urandom_range(99) < vpct);
      phv_in        = mk(seq);
      phv_out_ready = ($urandom_range(99) < rpct);
      tick();
      k++;
    end
    phv_in_valid  = 1'b0;
    phv_out_ready = 1'b1;
    check("drain_in_budget", exp_q.size(), 0);
  endtask

  int a0, p0, k;

  initial begin
    aresetn       = 1'b0;
    phv_in        = '0;
    phv_in_valid  = 1'b0;
    phv_out_ready = 1'b1;
    stage_bypass  = 5'h1F;

    // Reset state
    @(posedge axis_clk);
    #1;
    check("rst_ready", phv_in_ready, 0);
    check("rst_out_valid", phv_out_valid, 0);
    check("rst_inflight", inflight, 0);
    check("rst_in_cnt", phv_in_cnt, 0);
    check("rst_out_cnt", phv_out_cnt, 0);
    check("rst_bypass", bypass_active, 0);
    check("rst_errs", {lat_err, ovf_err}, 0);
    #5;
    aresetn = 1'b1;
    #1;
    check("ready_before_edge", phv_in_ready, 0);
    @(posedge axis_clk);
    #1;
    check("ready_after_edge", phv_in_ready, 1);
    check("bypass_loaded", bypass_active, 5'h1F);

    // 1: single PHV through the all-bypass chain
    first_out_cyc = -1;
    phv_in        = mk(seq);
    phv_in_valid  = 1'b1;
    tick();
    phv_in_valid = 1'b0;
    k = 0;
    while (n_pop < 1 && k < 100) begin tick(); k++; end
    check("t1_latency", first_out_cyc - last_acc_cyc, LAT1);
    check("t1_in_cnt", phv_in_cnt, 1);
    check("t1_out_cnt", phv_out_cnt, 1);
    check("t1_inflight", inflight, 0);

    // 2: backpressure fills exactly FIFO_DEPTH credits
    a0 = n_acc;
    p0 = n_pop;
    phv_out_ready = 1'b0;
    for (int c = 0; c < 80; c++) begin
      phv_in_valid = 1'b1;
      phv_in       = mk(seq);
      tick();
    end
    check("t2_accepted", n_acc - a0, 32);
    check("t2_ready_low", phv_in_ready, 0);
    check("t2_inflight", inflight, 32);
    check("t2_out_valid", phv_out_valid, 1);
    drive(100 - (n_acc - a0), 2000, 100, 100);
    check("t2_accepted_all", n_acc - a0, 100);
    check("t2_popped", n_pop - p0, 100);
    check("t2_errs", {lat_err, ovf_err}, 0);

    // 3: bypass change while streaming drains the chain first
    a0 = n_acc;
    for (int c = 0; c < 10; c++) begin
      phv_in_valid = 1'b1;
      phv_in       = mk(seq);
      tick();
    end
    stage_bypass = 5'h00;
    phv_in       = mk(seq);
    #1;
    check("t3_ready_drop", phv_in_ready, 0);
    k = 0;
    while (inflight != 0 && k < 200) begin tick(); k++; end
    check("t3_drained", inflight, 0);
    check("t3_bypass_held", bypass_active, 5'h1F);
    tick();
    check("t3_bypass_new", bypass_active, 5'h00);
    check("t3_ready_back", phv_in_ready, 1);
    drive(20, 500, 100, 100);
    check("t3_accepted", n_acc - a0, 30);
    first_out_cyc = -1;
    drive(1, 200, 100, 100);
    check("t3_latency_stages", first_out_cyc - last_acc_cyc, LAT1);

    // 4: throttled traffic on both sides
    a0 = n_acc;
    p0 = n_pop;
    drive(10000, 90000, 50, 30);
    check("t4_accepted", n_acc - a0, 10000);
    check("t4_popped", n_pop - p0, 10000);
    check("t4_in_cnt", phv_in_cnt, n_acc);
    check("t4_out_cnt", phv_out_cnt, n_pop);
    check("t4_lat_err", lat_err, 0);
    check("t4_ovf_err", ovf_err, 0);
    check("t4_spurious", n_spurious, 0);

    // 5: reset with 20 PHVs in flight
    for (int c = 0; c < 20; c++) begin
      phv_in_valid = 1'b1;
      phv_in       = mk(seq);
      tick();
    end
    phv_in_valid = 1'b0;
    check("t5_inflight_pre", inflight, 20);
    #2;
    aresetn = 1'b0;
    #1;
    check("t5_ready", phv_in_ready, 0);
    check("t5_out_valid", phv_out_valid, 0);
    chk_phv("t5_phv_out", phv_out, '0);
    check("t5_inflight", inflight, 0);
    check("t5_cnts", {phv_in_cnt, phv_out_cnt}, 0);
    check("t5_bypass", bypass_active, 0);
    exp_q.delete();
    n_acc     = 0;
    n_pop     = 0;
    hold_prev = 1'b0;
    @(negedge axis_clk);
    aresetn = 1'b1;
    @(posedge axis_clk);
    #1;
    cyc++;
    first_out_cyc = -1;
    for (int c = 0; c < 60; c++) tick();
    check("t5_no_stale", first_out_cyc, -1);
    check("t5_spurious", n_spurious, 0);
    drive(1, 200, 100, 100);
    check("t5_latency", first_out_cyc - last_acc_cyc, LAT1);
    check("t5_in_cnt", phv_in_cnt, 1);

    // 6: input counter wraps through 0xFFFFFFFF
    force dut.phv_in_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.phv_in_cnt;
    drive(3, 200, 100, 100);
    check("t6_in_cnt_wrap", phv_in_cnt, 1);
    check("t6_out_cnt", phv_out_cnt, n_pop);
    check("t6_errs", {lat_err, ovf_err}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
